// File: rtl/MIXER.sv
// Shared types, defaults and saturation helper for the sound mixer.
// Used by sound_mixer and mixer_dc_block.
package MIXER;

  localparam int DEF_CH_NUM    = 4;
  localparam int DEF_IN_WIDTH  = 10;
  localparam int DEF_OUT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SAT,
    DONE
  } state_t;

  // Clamp a signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mixer_dc_block.sv
// DC-blocking high-pass: y = x - x1 + y1 - (y1 >>> DC_SHIFT).
// Output registered and saturated; state advances only on valid samples.
module mixer_dc_block
  import MIXER::*;
#(
  parameter int WIDTH    = DEF_OUT_WIDTH,
  parameter int DC_SHIFT = 8
) (
  input  logic             CLK,
  input  logic             RESET_n,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_VALID
);

  localparam int IW = WIDTH + 2;

  logic signed [IW-1:0] x;
  logic signed [IW-1:0] y;
  logic signed [IW-1:0] x_prev;
  logic signed [IW-1:0] y_prev;

  assign x = IW'($signed(IN));
  assign y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT);

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      x_prev    <= '0;
      y_prev    <= '0;
      OUT       <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= IN_VALID;
      if (IN_VALID) begin
        x_prev <= x;
        y_prev <= y;
        OUT    <= WIDTH'(saturate(64'(y), WIDTH));
      end
    end
  end

endmodule

// File: rtl/sound_mixer.sv
// Time-multiplexed channel mixer: capture, serial sum, shift, saturate.
// Define MIXER_DC_BLOCK_EN to add the DC-blocking stage on the output.
module sound_mixer
  import MIXER::*;
#(
  parameter int CH_NUM     = DEF_CH_NUM,
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int GAIN_SHIFT = 0,
  parameter int DC_SHIFT   = 8
) (
  input  logic                       CLK,
  input  logic                       RESET_n,
  input  logic                       SAMPLE_EN,
  input  logic [CH_NUM*IN_WIDTH-1:0] IN,
  output logic                       BUSY,
  output logic [OUT_WIDTH-1:0]       OUT,
  output logic                       OUT_VALID
);

  localparam int XW    = $clog2(CH_NUM);
  localparam int ACC_W = IN_WIDTH + XW;
  localparam int S_W   = ACC_W + GAIN_SHIFT;
  localparam logic [XW-1:0] LAST = XW'(CH_NUM - 1);

  state_t state;
  state_t state_nx;

  logic [CH_NUM*IN_WIDTH-1:0] cap;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    ch_ext;
  logic signed [S_W-1:0]      scaled;
  logic signed [OUT_WIDTH-1:0] sat_q;
  logic [OUT_WIDTH-1:0]       out_q;
  logic [XW-1:0]              idx;
  logic                       busy_q;
  logic                       vld_q;
  logic                       blk;
  logic                       start;

  // Capture is shifted down each ACCUM cycle, so the low slot is current.
  assign ch_ext = ACC_W'($signed(cap[IN_WIDTH-1:0]));
  assign scaled = S_W'(acc) <<< GAIN_SHIFT;
  assign start  = SAMPLE_EN && (state == IDLE) && !blk;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = ACCUM;
      ACCUM: if (idx == LAST) state_nx = SAT;
      SAT:   state_nx = DONE;
      DONE:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cap    <= '0;
      acc    <= '0;
      idx    <= '0;
      sat_q  <= '0;
      out_q  <= '0;
      busy_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (start) begin
        cap    <= IN;
        acc    <= '0;
        idx    <= '0;
        busy_q <= 1'b1;
      end
      if (state == ACCUM) begin
        acc <= acc + ch_ext;
        cap <= cap >> IN_WIDTH;
        idx <= idx + 1'b1;
      end
      if (state == SAT)
        sat_q <= OUT_WIDTH'(saturate(64'(scaled), OUT_WIDTH));
      if (state == DONE) begin
        out_q  <= sat_q;
        vld_q  <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end

`ifdef MIXER_DC_BLOCK_EN
  // Stay busy while the filter registers the sample.
  assign blk  = vld_q;
  assign BUSY = busy_q | vld_q;

  mixer_dc_block #(
    .WIDTH   (OUT_WIDTH),
    .DC_SHIFT(DC_SHIFT)
  ) u_dc (
    .CLK      (CLK),
    .RESET_n  (RESET_n),
    .IN_VALID (vld_q),
    .IN       (out_q),
    .OUT      (OUT),
    .OUT_VALID(OUT_VALID)
  );
`else
  logic unused_dc_shift;
  assign unused_dc_shift = ^DC_SHIFT;
  assign blk       = 1'b0;
  assign BUSY      = busy_q;
  assign OUT       = out_q;
  assign OUT_VALID = vld_q;
`endif

endmodule

// File: tb/tb_sound_mixer.sv
// Bench for sound_mixer: gain 0 and gain 6 instances, shared stimulus.
// Scoreboard queues hold expected value and arrival cycle per instance.
module tb_sound_mixer;

  localparam int CH = 4;
  localparam int IW = 10;
  localparam int OW = 16;
`ifdef MIXER_DC_BLOCK_EN
  localparam int LAT = CH + 3;
`else
  localparam int LAT = CH + 2;
`endif
  localparam int GAP = LAT + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              se = 1'b0;
  logic [CH*IW-1:0]  in_bus = '0;
  logic              busy0, busy1, v0, v1;
  logic [OW-1:0]     out0, out1;

  always #5 clk = ~clk;

  sound_mixer #(
    .CH_NUM(CH), .IN_WIDTH(IW), .OUT_WIDTH(OW),
    .GAIN_SHIFT(0), .DC_SHIFT(8)
  ) dut0 (
    .CLK(clk), .RESET_n(rst_n), .SAMPLE_EN(se), .IN(in_bus),
    .BUSY(busy0), .OUT(out0), .OUT_VALID(v0)
  );

  sound_mixer #(
    .CH_NUM(CH), .IN_WIDTH(IW), .OUT_WIDTH(OW),
    .GAIN_SHIFT(6), .DC_SHIFT(8)
  ) dut1 (
    .CLK(clk), .RESET_n(rst_n), .SAMPLE_EN(se), .IN(in_bus),
    .BUSY(busy1), .OUT(out1), .OUT_VALID(v1)
  );

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  typedef struct {
    int a, b, c, d;
    int e0, e1;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   xp[2];
  int   yp[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int dcm(input int k, input int x);
    int y;
    y = x - xp[k] + yp[k] - (yp[k] >>> 8);
    xp[k] = x;
    yp[k] = y;
    return clamp(y);
  endfunction

  function automatic int expect_out(input int k, input int x);
`ifdef MIXER_DC_BLOCK_EN
    return dcm(k, x);
`else
    return x;
`endif
  endfunction

  function automatic logic [CH*IW-1:0] pk(input int a, input int b,
                                          input int c, input int d);
    return {d[IW-1:0], c[IW-1:0], b[IW-1:0], a[IW-1:0]};
  endfunction

  function automatic int bus_sum(input logic [CH*IW-1:0] p);
    int s = 0;
    for (int i = 0; i < CH; i++) s += int'($signed(p[i*IW +: IW]));
    return s;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe is sampled at the posedge following the first negedge.
  task automatic strobe(input logic [CH*IW-1:0] bus, input int x0,
                        input int x1, input bit push);
    @(negedge clk);
    in_bus = bus;
    se = 1'b1;
    if (push) begin
      q0.push_back('{expect_out(0, x0), cyc + 1 + LAT});
      q1.push_back('{expect_out(1, x1), cyc + 1 + LAT});
    end
    @(negedge clk);
    se = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && v0) begin
      if (q0.size() == 0) check("dut0 unexpected valid", 1, 0);
      else begin
        e0 = q0.pop_front();
        check("dut0 out", int'($signed(out0)), e0.val);
        check("dut0 latency cycle", cyc, e0.cyc);
      end
    end
    if (rst_n === 1'b1 && v1) begin
      if (q1.size() == 0) check("dut1 unexpected valid", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("dut1 out", int'($signed(out1)), e1.val);
        check("dut1 latency cycle", cyc, e1.cyc);
      end
    end
  end

  vec_t tbl[10];
  logic [CH*IW-1:0] bus;
  int s, n, t;
  int dcexp[3];

  initial begin
    tbl[0] = '{100, 200, -50, 7, 257, 16448};
    tbl[1] = '{511, 511, 511, 511, 2044, 32767};
    tbl[2] = '{-512, -512, -512, -512, -2048, -32768};
    tbl[3] = '{1, 1, 1, 1, 4, 256};
    tbl[4] = '{0, 0, 0, 0, 0, 0};
    tbl[5] = '{511, -512, 0, 0, -1, -64};
    tbl[6] = '{300, -100, 50, -1, 249, 15936};
    tbl[7] = '{511, 511, 0, 0, 1022, 32767};
    tbl[8] = '{-256, -256, 0, 0, -512, -32768};
    tbl[9] = '{255, 256, 0, 0, 511, 32704};
    dcexp = '{1000, 997, 994};
    for (int k = 0; k < 2; k++) begin xp[k] = 0; yp[k] = 0; end

    rst_n = 1'b0;
    idle(3);
    check("reset OUT", int'(out0), 0);
    check("reset OUT_VALID", int'(v0), 0);
    check("reset BUSY", int'(busy0), 0);
    check("reset OUT g6", int'(out1), 0);
    rst_n = 1'b1;
    idle(2);

`ifdef MIXER_DC_BLOCK_EN
    for (int k = 0; k < 3; k++) begin
      strobe(pk(250, 250, 250, 250), 0, 0, 1'b0);
      q0.push_back('{dcexp[k], cyc + LAT});
      q1.push_back('{dcm(1, 32767), cyc + LAT});
      s = dcm(0, 1000);
      idle(GAP - 1);
    end
    idle(2);
`endif

    // Basic mix with BUSY width measurement.
    strobe(pk(100, 200, -50, 7), 257, 16448, 1'b1);
    n = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      if (busy0) n++;
      @(negedge clk);
    end
    check("BUSY cycles", n, LAT);
    idle(2);

    // Table at the maximum accepted strobe rate.
    foreach (tbl[i]) begin
      strobe(pk(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d),
             tbl[i].e0, tbl[i].e1, 1'b1);
      idle(GAP - 2);
    end
    idle(LAT + 2);

    // Strobes while busy and in the DONE cycle are dropped.
    bus = pk(10, 20, 30, 40);
    strobe(bus, bus_sum(bus), clamp(bus_sum(bus) * 64), 1'b1);
    strobe(pk(-5, -6, -7, -8), 0, 0, 1'b0);
    idle(CH - 2);
    strobe(pk(9, 9, 9, 9), 0, 0, 1'b0);
    idle(LAT + 2);

    // IN changes after the strobe must not leak into the mix.
    bus = pk(-100, -200, 3, 4);
    s = bus_sum(bus);
    strobe(bus, s, clamp(s * 64), 1'b1);
    for (int k = 0; k < CH + 1; k++) begin
      in_bus = CH*IW'($urandom());
      @(negedge clk);
    end
    idle(LAT);

    // Reset in the middle of ACCUM aborts without a pulse.
    strobe(pk(400, 400, 400, 400), 0, 0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort OUT", int'(out0), 0);
    check("abort BUSY", int'(busy0), 0);
    check("abort OUT_VALID", int'(v0), 0);
    check("abort OUT g6", int'(out1), 0);
    for (int k = 0; k < 2; k++) begin xp[k] = 0; yp[k] = 0; end
    idle(2);
    rst_n = 1'b1;
    idle(LAT + 2);
    strobe(pk(1, 1, 1, 1), 4, 256, 1'b1);
    idle(GAP);

    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("pending expectations", q0.size() + q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_mixer.md
# sound_mixer

Time-multiplexed audio mixer that sits directly downstream of the per-channel constant attenuators. It captures CH_NUM signed, already-attenuated channel samples on a sample strobe and sums them sequentially with a single adder. The sum is scaled and saturated to the DAC/output width, then presented with a one-cycle valid pulse. An optional DC-blocking high-pass stage can be compiled in after saturation.

## Interface
Parameters:
- CH_NUM, 4: number of input channels (≥2).
- IN_WIDTH, 10: width of each signed two's-complement input channel.
- OUT_WIDTH, 16: width of the signed output (≥ IN_WIDTH).
- GAIN_SHIFT, 0: left shift applied to the sum before saturation (0..OUT_WIDTH-IN_WIDTH).
- DC_SHIFT, 8: pole shift of the DC blocker (used only when compiled in).

Ports:
- CLK  in  1  system clock.
- RESET_n  in  1  reset; RESET_n is asynchronous and active-low; the clock is CLK.
- SAMPLE_EN  in  1  one-cycle strobe; starts a mix.
- IN  in  CH_NUM*IN_WIDTH  packed channels; channel i occupies bits [i*IN_WIDTH +: IN_WIDTH].
- BUSY  out  1  high from the cycle after an accepted strobe until OUT_VALID.
- OUT  out  OUT_WIDTH  mixed sample; held between updates.
- OUT_VALID  out  1  one-cycle pulse when OUT updates.

## Operation
- Reset values: OUT=0, OUT_VALID=0, BUSY=0, FSM=IDLE, accumulator=0, capture register=0, DC-filter state=0.
- The FSM has four states: IDLE, ACCUM, SAT, DONE.
- IDLE: if SAMPLE_EN=1, latch all of IN into the capture register, clear the accumulator and the channel index, then go to ACCUM.
- ACCUM: each cycle, add sign-extended channel[index] to the accumulator and increment the index.
  - After channel CH_NUM-1 is added, go to SAT.
  - Accumulator width is IN_WIDTH + $clog2(CH_NUM), so it can never overflow.
- SAT: compute s = accumulator <<< GAIN_SHIFT, evaluated in IN_WIDTH+$clog2(CH_NUM)+GAIN_SHIFT bits.
  - Clamp s to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Register the clamped value and go to DONE.
- DONE: load OUT and pulse OUT_VALID. Return to IDLE.
- A SAMPLE_EN that arrives while not in IDLE (BUSY=1, or during the DONE cycle) is ignored and is not queued.
- A SAMPLE_EN in the same cycle that the FSM enters IDLE is accepted.
- IN only has to be stable in the strobe cycle; later changes do not affect the mix in progress.
- Reset during a mix aborts it: OUT returns to 0, no OUT_VALID is emitted, and the next strobe produces a clean result.

## Timing
- The strobe is sampled at edge 0.
- ACCUM occupies edges 1..CH_NUM, SAT edge CH_NUM+1, DONE edge CH_NUM+2.
- OUT and OUT_VALID are visible after edge CH_NUM+2. Latency is CH_NUM+2 cycles (6 with the defaults).
- With MIXER_DC_BLOCK_EN, latency is CH_NUM+3: the filter output is registered, and OUT_VALID is delayed by one cycle to stay aligned with OUT.
- BUSY is asserted from edge 0 until the edge that asserts OUT_VALID.
- Maximum accepted strobe rate is one per CH_NUM+3 cycles (CH_NUM+4 with the DC blocker).

## Configuration
- Macro: MIXER_DC_BLOCK_EN.
- Defined: the saturated sample x passes through y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> DC_SHIFT).
  - Internal width is OUT_WIDTH+2; >>> is an arithmetic, floor shift.
  - y is saturated to OUT_WIDTH before driving OUT.
  - x[n-1] and y[n-1] update only on valid samples.
- Undefined: the saturated sample drives OUT directly; no filter registers exist.

## Structure
- Package MIXER holds:
  - the state typedef (IDLE, ACCUM, SAT, DONE);
  - a saturate function parameterised by width;
  - localparam defaults for CH_NUM, IN_WIDTH and OUT_WIDTH.
- Sub-module mixer_dc_block implements the filter, with inputs CLK, RESET_n, IN_VALID, IN and outputs OUT, OUT_VALID.
  - It is instantiated only under MIXER_DC_BLOCK_EN.

## Test plan
- Defaults, no DC blocker. Channels 100, 200, -50, 7 with SAMPLE_EN → OUT=257 and OUT_VALID exactly 6 cycles after the strobe; BUSY high for 6 cycles.
- GAIN_SHIFT=6. All channels 511 → OUT=32767 (saturated). All channels -512 → OUT=-32768.
- Second SAMPLE_EN 2 cycles after the first, with different IN → ignored; only one OUT_VALID, with the first result.
- Change IN during ACCUM → result reflects only the values captured at the strobe.
- Assert RESET_n=0 mid-ACCUM → OUT=0, BUSY=0, no pulse. After release, channels 1, 1, 1, 1 → OUT=4.
- MIXER_DC_BLOCK_EN, DC_SHIFT=8. Repeated mixes with sum 1000 → OUT sequence 1000, 997, 994; latency 7 cycles.
